// File: rtl/tpx3_arb_pkg.sv
// Shared definitions for the tpx3 output schedulers: FSM states, tag width
// and the masked round-robin search used to pick the next source.
package tpx3_arb_pkg;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned TAG_W = 4;
  localparam int unsigned MAX_N = 16;

  typedef struct packed {
    logic             found;
    logic [TAG_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req_mask strictly after ptr, wrapping modulo n.
  function automatic rr_pick_t next_rr(input logic [TAG_W-1:0] ptr,
                                       input logic [MAX_N-1:0] req_mask,
                                       input int unsigned      n);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 1; k <= MAX_N; k++) begin
      cand = (32'(ptr) + k) % n;
      if (k <= n && !res.found && req_mask[cand[TAG_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[TAG_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/tpx3_rr_pick.sv
// Combinational round-robin picker: first requester after i_ptr, modulo N.
module tpx3_rr_pick
  import tpx3_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [TAG_W-1:0] i_ptr,
  input  logic [N-1:0]     i_req,
  output logic             o_found,
  output logic [TAG_W-1:0] o_idx
);

  logic [MAX_N-1:0] w_req_ext;
  rr_pick_t         w_pick;

  always_comb begin
    w_req_ext = MAX_N'(i_req);
    w_pick    = next_rr(i_ptr, w_req_ext, N);
    o_found   = w_pick.found;
    o_idx     = w_pick.idx;
  end

endmodule

// File: rtl/tpx3_burst_arbiter.sv
// Weighted round-robin burst scheduler sharing one output FIFO between N
// first-word-fall-through sources; one bubble cycle per grant.
module tpx3_burst_arbiter
  import tpx3_arb_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned DW        = 32,
  parameter int unsigned TAG_EN    = 1
) (
  input  logic            BUS_CLK,
  input  logic            BUS_RST,
  input  logic [N-1:0]    CH_ENABLE,
  input  logic [N-1:0]    SRC_EMPTY,
  input  logic [N*DW-1:0] SRC_DATA,
  input  logic [N-1:0]    SRC_HOLD,
  output logic [N-1:0]    SRC_READ,
  output logic            OUT_VALID,
  output logic [DW-1:0]   OUT_DATA,
  input  logic            OUT_READY,
  output logic [3:0]      CUR_CH,
  output logic            BUSY
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  arb_state_t       r_state;
  logic [TAG_W-1:0] r_rr_ptr;
  logic [TAG_W-1:0] r_cur_ch;
  logic [CW-1:0]    r_burst_cnt;
  logic             r_out_valid;
  logic [DW-1:0]    r_out_data;

  logic [N-1:0]     w_req;
  logic             w_found;
  logic [TAG_W-1:0] w_pick_idx;
  logic [N-1:0]     w_cur_onehot;
  logic             w_cur_empty;
  logic             w_cur_en;
  logic             w_cur_hold;
  logic [DW-1:0]    w_cur_data;
  logic [DW-1:0]    w_out_word;
  logic             w_can_load;
  logic             w_pop;
  logic [CW-1:0]    w_cnt_next;
  logic             w_burst_done;

  assign w_req = CH_ENABLE & ~SRC_EMPTY;

  tpx3_rr_pick #(.N(N)) u_pick (
    .i_ptr  (r_rr_ptr),
    .i_req  (w_req),
    .o_found(w_found),
    .o_idx  (w_pick_idx)
  );

  always_comb begin
    w_cur_onehot = '0;
    w_cur_empty  = 1'b1;
    w_cur_en     = 1'b0;
    w_cur_hold   = 1'b0;
    w_cur_data   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_cur_ch == TAG_W'(i)) begin
        w_cur_onehot[i] = 1'b1;
        w_cur_empty     = SRC_EMPTY[i];
        w_cur_en        = CH_ENABLE[i];
        w_cur_hold      = SRC_HOLD[i];
        w_cur_data      = SRC_DATA[i*DW +: DW];
      end
    end
    w_out_word = w_cur_data;
    if (TAG_EN != 0) w_out_word[DW-1 -: TAG_W] = r_cur_ch;
  end

  assign w_can_load   = ~r_out_valid | OUT_READY;
  assign w_pop        = (r_state == ST_GRANT) & w_can_load & ~w_cur_empty & w_cur_en;
  assign SRC_READ     = w_pop ? w_cur_onehot : '0;
  // Counter saturates so HOLD can stretch a burst indefinitely.
  assign w_cnt_next   = (r_burst_cnt == CW'(MAX_BURST)) ? r_burst_cnt : r_burst_cnt + 1'b1;
  assign w_burst_done = w_pop & (w_cnt_next >= CW'(MAX_BURST)) & ~w_cur_hold;

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      r_state     <= ST_ARB;
      r_rr_ptr    <= TAG_W'(N - 1);
      r_cur_ch    <= '0;
      r_burst_cnt <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (r_out_valid & OUT_READY) r_out_valid <= 1'b0;
          if (w_found) begin
            r_cur_ch    <= w_pick_idx;
            r_rr_ptr    <= w_pick_idx;
            r_burst_cnt <= '0;
            r_state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_pop) begin
            r_out_data  <= w_out_word;
            r_out_valid <= 1'b1;
            r_burst_cnt <= w_cnt_next;
          end else if (w_can_load) begin
            r_out_valid <= 1'b0;
          end
          if (w_burst_done | w_cur_empty | ~w_cur_en) r_state <= ST_ARB;
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

  assign OUT_VALID = r_out_valid;
  assign OUT_DATA  = r_out_data;
  assign CUR_CH    = r_cur_ch;
  assign BUSY      = (r_state == ST_GRANT);

endmodule

// File: tb/tb_tpx3_burst_arbiter.sv
// Bench for tpx3_burst_arbiter: queue-based source model, per-cycle compare
// against a behavioural scheduler model, directed scenarios plus random run.
module tb_tpx3_burst_arbiter;
  localparam int N  = 4;
  localparam int MB = 16;
  localparam int DW = 32;

  logic            BUS_CLK = 1'b0;
  logic            BUS_RST = 1'b0;
  logic [N-1:0]    CH_ENABLE = '1;
  logic [N-1:0]    SRC_EMPTY = '1;
  logic [N*DW-1:0] SRC_DATA = '0;
  logic [N-1:0]    SRC_HOLD = '0;
  logic [N-1:0]    SRC_READ;
  logic            OUT_VALID;
  logic [DW-1:0]   OUT_DATA;
  logic            OUT_READY = 1'b1;
  logic [3:0]      CUR_CH;
  logic            BUSY;

  tpx3_burst_arbiter #(.N(N), .MAX_BURST(MB), .DW(DW), .TAG_EN(1)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .CH_ENABLE(CH_ENABLE),
    .SRC_EMPTY(SRC_EMPTY), .SRC_DATA(SRC_DATA), .SRC_HOLD(SRC_HOLD),
    .SRC_READ(SRC_READ), .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA),
    .OUT_READY(OUT_READY), .CUR_CH(CUR_CH), .BUSY(BUSY)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  // Source FIFOs and HOLD policy
  logic [DW-1:0] q[N][$];
  int            popcnt[N];
  int            hold_lim[N];
  logic [N-1:0]  hold_rand = '0;

  // Behavioural scheduler model
  bit            m_grant, m_valid;
  int            m_cur, m_rr, m_cnt;
  logic [DW-1:0] m_data;
  int            log_ch[$], log_len[$];
  int            wait_g[N];

  int            errors = 0, checks = 0;
  bit            chk_en = 0;
  logic [DW-1:0] acc_q[$];
  int            acc_words, rd_pulses, rd_ch1;
  bit            prev_hold_valid;
  logic [DW-1:0] prev_data;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] m_read();
    if (m_grant && (!m_valid || OUT_READY) && q[m_cur].size() > 0 && CH_ENABLE[m_cur])
      return N'(1) << m_cur;
    return '0;
  endfunction

  function automatic bit m_idle();
    bit any = 0;
    for (int i = 0; i < N; i++) if (CH_ENABLE[i] && q[i].size() > 0) any = 1;
    return !m_grant && !m_valid && !any;
  endfunction

  task automatic m_reset();
    m_grant = 0; m_valid = 0; m_cur = 0; m_rr = N - 1; m_cnt = 0; m_data = '0;
    prev_hold_valid = 0;
    for (int i = 0; i < N; i++) wait_g[i] = 0;
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      SRC_EMPTY[i]          = (q[i].size() == 0);
      SRC_DATA[i*DW +: DW]  = (q[i].size() == 0) ? '0 : q[i][0];
      SRC_HOLD[i]           = (popcnt[i] < hold_lim[i]) | hold_rand[i];
    end
  endtask

  task automatic push(input int s, input logic [DW-1:0] d);
    q[s].push_back(d);
    drive_srcs();
  endtask

  task automatic tick();
    @(posedge BUS_CLK); #1;
    drive_srcs();
  endtask

  // Model advance on each clock edge using the pre-edge inputs.
  always @(posedge BUS_CLK) begin
    if (chk_en && !BUS_RST) begin
      bit can_load;
      can_load = !m_valid || OUT_READY;
      if (m_grant) begin
        bit leave;
        leave = (q[m_cur].size() == 0) || !CH_ENABLE[m_cur];
        if (can_load && !leave) begin
          logic [DW-1:0] d;
          d = q[m_cur].pop_front();
          popcnt[m_cur]++;
          m_data  = {4'(m_cur), d[DW-5:0]};
          m_valid = 1;
          m_cnt   = (m_cnt < MB) ? m_cnt + 1 : MB;
          log_len[log_len.size()-1]++;
          if (m_cnt >= MB && !SRC_HOLD[m_cur]) leave = 1;
        end else if (can_load) m_valid = 0;
        if (leave) m_grant = 0;
      end else begin
        if (m_valid && OUT_READY) m_valid = 0;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_rr + k) % N;
          if (!m_grant && CH_ENABLE[c] && q[c].size() > 0) begin
            for (int i = 0; i < N; i++) begin
              if (i == c) wait_g[i] = 0;
              else if (CH_ENABLE[i] && q[i].size() > 0) begin
                wait_g[i]++;
                check("starvation_bound", 64'(wait_g[i] < N), 64'd1);
              end else wait_g[i] = 0;
            end
            m_grant = 1; m_cur = c; m_rr = c; m_cnt = 0;
            log_ch.push_back(c); log_len.push_back(0);
          end
        end
      end
    end
  end

  // Compare process, away from the active edge.
  always @(negedge BUS_CLK) begin
    if (chk_en && !BUS_RST) begin
      check("SRC_READ", 64'(SRC_READ), 64'(m_read()));
      check("OUT_VALID", 64'(OUT_VALID), 64'(m_valid));
      check("OUT_DATA", 64'(OUT_DATA), 64'(m_data));
      check("CUR_CH", 64'(CUR_CH), 64'(m_cur));
      check("BUSY", 64'(BUSY), 64'(m_grant));
      if (prev_hold_valid) check("stall_data_stable", 64'(OUT_DATA), 64'(prev_data));
      prev_hold_valid = OUT_VALID && !OUT_READY;
      prev_data       = OUT_DATA;
      if (OUT_VALID && OUT_READY) begin acc_q.push_back(OUT_DATA); acc_words++; end
      rd_pulses += $countones(SRC_READ);
      rd_ch1    += int'(SRC_READ[1]);
    end
  end

  task automatic wait_idle(input int budget, input string nm);
    for (int c = 0; c < budget; c++) begin
      if (m_idle()) return;
      tick();
    end
    errors++; checks++;
    $display("FAIL %s: timeout after %0d cycles, idle=0 required 1", nm, budget);
  endtask

  task automatic clear_logs();
    log_ch.delete(); log_len.delete(); acc_q.delete();
    acc_words = 0; rd_pulses = 0; rd_ch1 = 0;
    for (int i = 0; i < N; i++) popcnt[i] = 0;
  endtask

  initial begin
    logic [DW-1:0] exp2[5];
    int            e_ch[6], e_len[6];
    int            pushed;
    e_ch  = '{0, 1, 0, 1, 0, 1};
    e_len = '{16, 16, 16, 16, 8, 8};
    for (int i = 0; i < N; i++) hold_lim[i] = 0;
    clear_logs();

    // 1: reset pulse mid-clock, then idle
    #12 BUS_RST = 1; m_reset(); #3 BUS_RST = 0; chk_en = 1;
    check("reset_OUT_VALID", 64'(OUT_VALID), 64'd0);
    check("reset_OUT_DATA", 64'(OUT_DATA), 64'd0);
    repeat (20) tick();
    check("idle_BUSY", 64'(BUSY), 64'd0);
    check("idle_SRC_READ", 64'(SRC_READ), 64'd0);
    check("idle_CUR_CH", 64'(CUR_CH), 64'd0);

    // 2: single source, 5 words, tag overwrites top nibble
    clear_logs();
    for (int k = 0; k < 5; k++) begin
      logic [DW-1:0] d;
      d = $urandom;
      exp2[k] = {4'd2, d[DW-5:0]};
      push(2, d);
    end
    wait_idle(60, "single_drain");
    check("single_bursts", 64'(log_ch.size()), 64'd1);
    check("single_ch", 64'(log_ch[0]), 64'd2);
    check("single_len", 64'(log_len[0]), 64'd5);
    check("single_count", 64'(acc_q.size()), 64'd5);
    for (int k = 0; k < 5 && k < acc_q.size(); k++) check("single_word", 64'(acc_q[k]), 64'(exp2[k]));

    // 3: fairness between sources 0 and 1
    clear_logs();
    for (int k = 0; k < 40; k++) begin push(0, 32'h0000_1000 + k); push(1, 32'h0000_2000 + k); end
    wait_idle(400, "fair_drain");
    check("fair_bursts", 64'(log_ch.size()), 64'd6);
    for (int b = 0; b < 6 && b < log_ch.size(); b++) begin
      check("fair_ch", 64'(log_ch[b]), 64'(e_ch[b]));
      check("fair_len", 64'(log_len[b]), 64'(e_len[b]));
    end
    check("fair_words", 64'(acc_words), 64'd80);

    // 4: back-pressure pattern 1,0,0,1
    clear_logs();
    for (int k = 0; k < 20; k++) push(3, $urandom);
    for (int c = 0; c < 300 && !m_idle(); c++) begin
      tick();
      OUT_READY = (c % 4 == 0) || (c % 4 == 3);
    end
    OUT_READY = 1;
    wait_idle(100, "bp_drain");
    check("bp_words", 64'(acc_words), 64'd20);
    check("bp_reads_eq_accepts", 64'(rd_pulses), 64'(acc_words));

    // 5: HOLD stretches source 3 to a 30-word burst
    clear_logs();
    hold_lim[3] = 29;
    for (int k = 0; k < 40; k++) push(3, 32'h0000_3000 + k);
    repeat (3) tick();
    for (int k = 0; k < 40; k++) push(0, 32'h0000_4000 + k);
    wait_idle(600, "hold_drain");
    hold_lim[3] = 0; drive_srcs();
    check("hold_first_ch", 64'(log_ch[0]), 64'd3);
    check("hold_first_len", 64'(log_len[0]), 64'd30);
    check("hold_second_ch", 64'(log_ch[1]), 64'd0);
    check("hold_second_len", 64'(log_len[1]), 64'd16);

    // 6a: disable source 1 after its fourth word
    clear_logs();
    for (int k = 0; k < 10; k++) push(1, 32'h0000_5000 + k);
    repeat (3) tick();
    for (int k = 0; k < 10; k++) push(2, 32'h0000_6000 + k);
    for (int c = 0; c < 100 && popcnt[1] < 4; c++) tick();
    CH_ENABLE[1] = 0;
    wait_idle(200, "disable_drain");
    check("disable_reads1", 64'(rd_ch1), 64'd4);
    check("disable_next_ch", 64'(log_ch[1]), 64'd2);
    q[1].delete(); tick(); CH_ENABLE[1] = 1;

    // 6b: asynchronous reset while OUT_VALID is high
    OUT_READY = 0;
    for (int k = 0; k < 3; k++) push(0, $urandom);
    for (int c = 0; c < 20 && !m_valid; c++) tick();
    #2 BUS_RST = 1; m_reset();
    #1 check("async_rst_valid", 64'(OUT_VALID), 64'd0);
    check("async_rst_busy", 64'(BUSY), 64'd0);
    for (int i = 0; i < N; i++) q[i].delete();
    drive_srcs(); OUT_READY = 1;
    #1 BUS_RST = 0;
    tick();

    // Random traffic
    clear_logs(); pushed = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      OUT_READY = ($urandom_range(0, 3) != 0);
      hold_rand = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      if (c % 50 == 0) CH_ENABLE = N'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        int s;
        s = $urandom_range(0, N - 1);
        if (q[s].size() < 64) begin push(s, $urandom); pushed++; end
      end
      drive_srcs();
    end
    CH_ENABLE = '1; OUT_READY = 1; hold_rand = '0; drive_srcs();
    wait_idle(3000, "random_drain");
    check("random_all_delivered", 64'(acc_words), 64'(pushed));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
